layer_compositor: RTL and testbench

- Parametrised video layer compositor between the sprite/map renderers and the TMDS encoders.
- Accepts NUM_LAYERS RGB layers, each with its own fixed render latency, and aligns them to a common ALIGN_LATENCY.
- Composites the aligned layers according to a mode: select, priority with colour key, or 50% blend.
- Delays hsync/vsync/active-draw so outputs arrive aligned with the composited pixel. Mode changes take effect only at frame boundaries, so there is no tearing.

---
 rtl/layer_compositor.sv | 169 ++++++++++++++++
 tb/tb_layer_compositor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Video layer compositor: aligns NUM_LAYERS RGB layers that have different
// render latencies to one common point, then composites them according to a
// frame-latched mode. Sync and active-draw strobes are delayed to match.
module layer_compositor #(
    parameter int unsigned NUM_LAYERS = 2,
    parameter logic [8*NUM_LAYERS-1:0] LAYER_LATENCY = {8'd0, 8'd48},
    parameter int unsigned ALIGN_LATENCY = 48,
    localparam int unsigned SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [24*NUM_LAYERS-1:0] rgb_in,
    input  logic                     hs_in,
    input  logic                     vs_in,
    input  logic                     ad_in,
    input  logic                     nf_in,
    input  logic [1:0]               mode_in,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [23:0]              key_in,
    input  logic [23:0]              bg_in,
    output logic [23:0]              rgb_out,
    output logic                     hs_out,
    output logic                     vs_out,
    output logic                     ad_out,
    output logic [1:0]               mode_out
);

    localparam int unsigned CTL_W = 4;
    localparam int unsigned HS_B  = 0;
    localparam int unsigned VS_B  = 1;
    localparam int unsigned AD_B  = 2;
    localparam int unsigned NF_B  = 3;

    if (NUM_LAYERS < 1 || NUM_LAYERS > 8) begin : g_bad_num
        $error("layer_compositor: NUM_LAYERS must be 1..8");
    end

    logic [23:0]      aligned_c [NUM_LAYERS];
    logic [CTL_W-1:0] ctl_c;
    logic [CTL_W-1:0] ctl_al_c;

    // Applied configuration (mode lives directly in mode_out)
    logic [SEL_W-1:0] cfg_sel;
    logic [23:0]      cfg_key;
    logic [23:0]      cfg_bg;

    assign ctl_c = {nf_in, ad_in, vs_in, hs_in};

    // Per-layer alignment delay; a layer already at the alignment point is a wire
    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        localparam int unsigned LAT = 32'(LAYER_LATENCY[8*i +: 8]);
        if (LAT > ALIGN_LATENCY) begin : g_bad_lat
            $error("layer_compositor: layer latency exceeds ALIGN_LATENCY");
        end else if (LAT == ALIGN_LATENCY) begin : g_wire
            assign aligned_c[i] = rgb_in[24*i +: 24];
        end else begin : g_dly
            localparam int unsigned D = ALIGN_LATENCY - LAT;
            logic [23:0] pipe [D];

            // Shift register of D stages, flushed on reset
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    for (int k = 0; k < D; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= rgb_in[24*i +: 24];
                    for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
                end
            end

            assign aligned_c[i] = pipe[D-1];
        end
    end

    // Timing strobes travel the full alignment delay
    if (ALIGN_LATENCY == 0) begin : g_ctl_wire
        assign ctl_al_c = ctl_c;
    end else begin : g_ctl_dly
        logic [CTL_W-1:0] ctl_pipe [ALIGN_LATENCY];

        // Strobe shift register, flushed on reset
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                for (int k = 0; k < ALIGN_LATENCY; k++) ctl_pipe[k] <= '0;
            end else begin
                ctl_pipe[0] <= ctl_c;
                for (int k = 1; k < ALIGN_LATENCY; k++) ctl_pipe[k] <= ctl_pipe[k-1];
            end
        end

        assign ctl_al_c = ctl_pipe[ALIGN_LATENCY-1];
    end

    // Config is captured only on the aligned new-frame pulse to avoid tearing
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mode_out <= 2'd0;
            cfg_sel  <= '0;
            cfg_key  <= '0;
            cfg_bg   <= '0;
        end else if (ctl_al_c[NF_B]) begin
            mode_out <= mode_in;
            cfg_sel  <= sel_in;
            cfg_key  <= key_in;
            cfg_bg   <= bg_in;
        end
    end

    logic [23:0] sel_pix_c;
    logic [23:0] key_pix_c;
    logic [23:0] blend_pix_c;
    logic [23:0] pix_c;

    // Mode 0: pick the selected layer; an out-of-range select shows background
    always_comb begin
        sel_pix_c = cfg_bg;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cfg_sel == SEL_W'(i)) sel_pix_c = aligned_c[i];
        end
    end

    // Mode 1: lowest-numbered non-key layer wins; scan downward so it lands last
    always_comb begin
        key_pix_c = cfg_bg;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (aligned_c[i] != cfg_key) key_pix_c = aligned_c[i];
        end
    end

    // Mode 2: per-channel floor average of layers 0 and 1
    if (NUM_LAYERS > 1) begin : g_blend
        function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
            return 8'((9'(a) + 9'(b)) >> 1);
        endfunction

        assign blend_pix_c = {avg8(aligned_c[0][23:16], aligned_c[1][23:16]),
                              avg8(aligned_c[0][15:8],  aligned_c[1][15:8]),
                              avg8(aligned_c[0][7:0],   aligned_c[1][7:0])};
    end else begin : g_no_blend
        assign blend_pix_c = sel_pix_c;
    end

    // Final pixel mux with blanking override
    always_comb begin
        pix_c = cfg_bg;
        case (mode_out)
            2'd0:    pix_c = sel_pix_c;
            2'd1:    pix_c = key_pix_c;
            2'd2:    pix_c = blend_pix_c;
            default: pix_c = cfg_bg;
        endcase
        if (!ctl_al_c[AD_B]) pix_c = 24'h0;
    end

    // Compose output register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rgb_out <= '0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
            ad_out  <= 1'b0;
        end else begin
            rgb_out <= pix_c;
            hs_out  <= ctl_al_c[HS_B];
            vs_out  <= ctl_al_c[VS_B];
            ad_out  <= ctl_al_c[AD_B];
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: directed pixels push hand-computed
// expectations with their due cycle; a monitor compares on the falling edge.
module tb_layer_compositor;

    logic        clk_pixel = 1'b0;
    logic        rst_in    = 1'b1;
    logic [47:0] rgb_in    = '0;
    logic        hs_in = 1'b0, vs_in = 1'b0, ad_in = 1'b0, nf_in = 1'b0;
    logic [1:0]  mode_in   = 2'd0;
    logic        sel_in    = 1'b0;
    logic [23:0] key_in    = '0;
    logic [23:0] bg_in     = '0;
    logic [23:0] rgb_out;
    logic        hs_out, vs_out, ad_out;
    logic [1:0]  mode_out;

    // Single-layer build for the out-of-range select and mode 2 fallback
    logic [23:0] n1_rgb_in = '0;
    logic        n1_ad_in = 1'b0, n1_nf_in = 1'b0;
    logic [1:0]  n1_mode_in = 2'd0;
    logic        n1_sel_in = 1'b0;
    logic [23:0] n1_bg_in = '0;
    logic [23:0] n1_rgb_out;
    logic        n1_hs_out, n1_vs_out, n1_ad_out;
    logic [1:0]  n1_mode_out;

    layer_compositor dut (
        .clk_in(clk_pixel), .rst_in(rst_in), .rgb_in(rgb_in),
        .hs_in(hs_in), .vs_in(vs_in), .ad_in(ad_in), .nf_in(nf_in),
        .mode_in(mode_in), .sel_in(sel_in), .key_in(key_in), .bg_in(bg_in),
        .rgb_out(rgb_out), .hs_out(hs_out), .vs_out(vs_out), .ad_out(ad_out),
        .mode_out(mode_out)
    );

    layer_compositor #(
        .NUM_LAYERS(1), .LAYER_LATENCY(8'd0), .ALIGN_LATENCY(2)
    ) dut_n1 (
        .clk_in(clk_pixel), .rst_in(rst_in), .rgb_in(n1_rgb_in),
        .hs_in(1'b0), .vs_in(1'b0), .ad_in(n1_ad_in), .nf_in(n1_nf_in),
        .mode_in(n1_mode_in), .sel_in(n1_sel_in), .key_in(24'h0), .bg_in(n1_bg_in),
        .rgb_out(n1_rgb_out), .hs_out(n1_hs_out), .vs_out(n1_vs_out), .ad_out(n1_ad_out),
        .mode_out(n1_mode_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    int edge_n = 0;
    always @(posedge clk_pixel) edge_n <= edge_n + 1;

    typedef struct {
        int          tgt;
        bit          which;
        logic [23:0] rgb;
        logic        hs, vs, ad;
        logic [1:0]  mode;
        string       nm;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] l0_sched [int];
    int          checks   = 0;
    int          failures = 0;

    // Monitor: compare every expectation that falls due on this cycle
    always @(negedge clk_pixel) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].tgt == edge_n) begin
                exp_t        e;
                logic [28:0] act, want;
                e = exp_q[i];
                if (e.which)
                    act = {n1_rgb_out, n1_hs_out, n1_vs_out, n1_ad_out, n1_mode_out};
                else
                    act = {rgb_out, hs_out, vs_out, ad_out, mode_out};
                want = {e.rgb, e.hs, e.vs, e.ad, e.mode};
                checks++;
                if (act !== want) begin
                    failures++;
                    $display("FAIL %s @%0d: got rgb=%h hs=%b vs=%b ad=%b mode=%0d, want rgb=%h hs=%b vs=%b ad=%b mode=%0d",
                             e.nm, edge_n, act[28:5], act[4], act[3], act[2], act[1:0],
                             e.rgb, e.hs, e.vs, e.ad, e.mode);
                end
                exp_q.delete(i);
            end
        end
    end

    // One cycle of main-DUT stimulus; layer 0 is scheduled 48 cycles later
    task automatic drive(input logic [23:0] a1, input logic [23:0] a0,
                         input logic ad, input logic hs, input logic vs,
                         input logic nf, input logic rst);
        @(negedge clk_pixel);
        l0_sched[edge_n + 48] = a0;
        rgb_in[47:24] = a1;
        rgb_in[23:0]  = l0_sched.exists(edge_n) ? l0_sched[edge_n] : 24'h0;
        ad_in  = ad;
        hs_in  = hs;
        vs_in  = vs;
        nf_in  = nf;
        rst_in = rst;
    endtask

    task automatic expect_at(input int off, input bit which, input logic [23:0] rgb,
                             input logic hs, input logic vs, input logic ad,
                             input logic [1:0] mode, input string nm);
        exp_t e;
        e.tgt = edge_n + off; e.which = which; e.rgb = rgb;
        e.hs = hs; e.vs = vs; e.ad = ad; e.mode = mode; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic new_frame();
        drive(24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pix(input logic [23:0] a1, input logic [23:0] a0,
                       input logic [23:0] e_rgb, input logic [1:0] e_mode, input string nm);
        drive(a1, a0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(49, 1'b0, e_rgb, 1'b0, 1'b0, 1'b1, e_mode, nm);
    endtask

    task automatic drive_n1(input logic [23:0] a, input logic ad, input logic nf);
        @(negedge clk_pixel);
        n1_rgb_in = a;
        n1_ad_in  = ad;
        n1_nf_in  = nf;
    endtask

    initial begin
        // Reset state
        drive(24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 2'd0, "reset_state");
        drive(24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (rgb_out !== 24'h0) begin
            failures++;
            $display("FAIL reset_rgb: got %h", rgb_out);
        end
        checks++;
        if ({hs_out, vs_out, ad_out} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes: got hs=%b vs=%b ad=%b", hs_out, vs_out, ad_out);
        end
        checks++;
        if (mode_out !== 2'd0) begin
            failures++;
            $display("FAIL reset_mode: got %0d", mode_out);
        end
        checks++;
        if (n1_rgb_out !== 24'h0) begin
            failures++;
            $display("FAIL n1_reset_rgb: got %h", n1_rgb_out);
        end
        checks++;
        if (n1_mode_out !== 2'd0) begin
            failures++;
            $display("FAIL n1_reset_mode: got %0d", n1_mode_out);
        end
        idle(2);

        // Latency: mode 0 sel 1, one strobed pixel plus its neighbours
        mode_in = 2'd0; sel_in = 1'b1;
        new_frame();
        idle(3);
        drive(24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(49, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 2'd0, "latency_pre");
        drive(24'hFF0000, 24'h111111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_at(49, 1'b0, 24'hFF0000, 1'b1, 1'b1, 1'b1, 2'd0, "latency_px");
        drive(24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(49, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 2'd0, "latency_post");
        idle(55);

        // Blend with layer 0 arriving 48 cycles after layer 1
        mode_in = 2'd2;
        new_frame();
        idle(2);
        pix(24'h304050, 24'h102030, 24'h203040, 2'd2, "blend_basic");
        pix(24'h000000, 24'h010101, 24'h000000, 2'd2, "blend_floor");
        pix(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 2'd2, "blend_max");
        pix(24'h01FF00, 24'hFF00FF, 24'h807F7F, 2'd2, "blend_mix");
        idle(55);

        // Priority with colour key
        mode_in = 2'd1; key_in = 24'h00FF00; bg_in = 24'hABCDEF;
        new_frame();
        idle(2);
        pix(24'h123456, 24'h00FF00, 24'h123456, 2'd1, "key_skip_l0");
        pix(24'h00FF00, 24'h00FF00, 24'hABCDEF, 2'd1, "key_all_bg");
        pix(24'h00FF00, 24'h112233, 24'h112233, 2'd1, "key_l0");
        pix(24'h445566, 24'h112233, 24'h112233, 2'd1, "key_prio");
        // Blanking with non-zero layers
        drive(24'h445566, 24'h112233, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(49, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 2'd1, "blanking");
        idle(50);

        // Mid-frame mode change is held off until the next frame pulse
        pix(24'h000000, 24'h112233, 24'h112233, 2'd1, "pre_change");
        mode_in = 2'd3;
        idle(3);
        pix(24'h000000, 24'h112233, 24'h112233, 2'd1, "change_ignored");
        new_frame();
        pix(24'h000000, 24'h112233, 24'hABCDEF, 2'd3, "after_latch");
        idle(55);

        // Config present at the latch cycle wins over the one at the pulse
        new_frame();
        idle(10);
        mode_in = 2'd2;
        idle(2);
        pix(24'h304050, 24'h102030, 24'h203040, 2'd2, "latch_value_wins");
        idle(55);

        // Reset in the middle of active video
        repeat (50) drive(24'h304050, 24'h102030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(24'h304050, 24'h102030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(49, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 2'd0, "flushed");
        repeat (4) drive(24'h304050, 24'h102030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(24'h304050, 24'h102030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 2'd0, "reset_mid_frame");
        pix(24'h304050, 24'h102030, 24'h102030, 2'd0, "resume_after_reset");
        idle(55);

        // Single-layer build: sel 1 is out of range, mode 2 falls back to select
        n1_mode_in = 2'd0; n1_sel_in = 1'b1; n1_bg_in = 24'h5A5A5A;
        drive_n1(24'h0, 1'b0, 1'b1);
        repeat (4) drive_n1(24'h0, 1'b0, 1'b0);
        drive_n1(24'h00C0DE, 1'b1, 1'b0);
        expect_at(3, 1'b1, 24'h5A5A5A, 1'b0, 1'b0, 1'b1, 2'd0, "n1_sel_out_of_range");
        repeat (4) drive_n1(24'h0, 1'b0, 1'b0);
        n1_mode_in = 2'd2; n1_sel_in = 1'b0;
        drive_n1(24'h0, 1'b0, 1'b1);
        repeat (4) drive_n1(24'h0, 1'b0, 1'b0);
        drive_n1(24'h00C0DE, 1'b1, 1'b0);
        expect_at(3, 1'b1, 24'h00C0DE, 1'b0, 1'b0, 1'b1, 2'd2, "n1_blend_as_select");
        repeat (6) drive_n1(24'h0, 1'b0, 1'b0);
        idle(3);

        // Anything still queued never fell due
        checks++;
        if (exp_q.size() != 0) begin
            foreach (exp_q[i]) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                         exp_q[i].nm, exp_q[i].tgt, edge_n);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
